csr_commit_ctrl: RTL and testbench
==================================

Name: csr_commit_ctrl

Overview:
- Initiator side of the CSR access interface.
- Sits at the writeback end of the pipeline and serialises CSR instructions, ERTN and exceptions into the CSR file.
- Drives read/write strobes, exception commit and ertn_flush; returns the old CSR value to the register file; issues the pipeline flush with a redirect PC.
- One instruction in flight; upstream sees a valid/ready handshake.

Parameters:
- DATA_W, 32, data/PC width.
- CSRN_W, 14, CSR number width.
- ECODE_INT, 6'h00, ecode committed for an interrupt.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  instruction offered by MEM stage
- in_ready  out  1  unit can accept
- in_pc  in  32  instruction PC
- in_op  in  3  0 NOP, 1 CSRRD, 2 CSRWR, 3 CSRXCHG, 4 ERTN
- in_csr_num  in  14  target CSR
- in_rj_val  in  32  CSRXCHG write mask
- in_rd_val  in  32  CSR write data
- in_rd  in  5  destination GPR
- in_ex  in  1  upstream exception
- in_ecode  in  6  upstream ecode
- in_esubcode  in  9  upstream esubcode
- in_vaddr  in  32  faulting address
- csr_re  out  1  CSR read strobe
- csr_num  out  14  CSR number
- csr_we  out  1  CSR write strobe
- csr_wmask  out  32  write mask
- csr_wvalue  out  32  write data
- csr_rvalue  in  32  CSR read data (combinational)
- has_int  in  1  pending enabled interrupt
- ex_entry  in  32  exception entry
- era  in  32  return address
- wb_ex  out  1  exception commit strobe
- wb_pc  out  32  exception PC
- wb_vaddr  out  32  exception address
- wb_ecode  out  6  exception ecode
- wb_esubcode  out  9  exception esubcode
- ertn_flush  out  1  ERTN commit strobe
- rf_we  out  1  GPR write enable
- rf_waddr  out  5  GPR address
- rf_wdata  out  32  GPR data
- flush  out  1  pipeline flush pulse
- flush_pc  out  32  redirect target
- perf_ex_cnt  out  32  exception counter
- perf_int_cnt  out  32  interrupt counter

Behaviour:
- Reset state:
  - Reset is asynchronous: all strobes (csr_re, csr_we, wb_ex, ertn_flush, rf_we, flush) drop to 0 immediately.
  - All data outputs reset to 0; FSM goes to IDLE.
  - Reset mid-instruction aborts it with no CSR side effect after the reset edge.
- FSM states IDLE -> EXEC -> RESP -> IDLE.
  - in_ready = (state==IDLE).
  - Accept on in_valid&&in_ready; all in_* fields are registered at the accept edge.
- Latency: accept at edge N; EXEC occupies cycle N+1; RESP occupies cycle N+2; next accept at edge N+3.
- EXEC cycle (all strobes are single-cycle, combinational from registered fields):
  - Classification priority: has_int > in_ex > ERTN > CSR op.
  - Interrupt: wb_ex=1, ecode=ECODE_INT, esubcode=0, wb_pc=in_pc. The CSR access and GPR write are suppressed.
  - Exception: wb_ex=1 with the registered ecode/esubcode/vaddr. CSR access is suppressed.
  - ERTN: ertn_flush=1.
  - CSRRD: csr_re=1.
  - CSRWR: csr_re=1, csr_we=1, wmask=32'hFFFFFFFF, wvalue=in_rd_val.
  - CSRXCHG: csr_re=1, csr_we=1, wmask=in_rj_val, wvalue=in_rd_val.
  - NOP: no strobes.
  - csr_num is held at the registered number in every state; it is 0 after reset.
  - csr_rvalue, ex_entry and era are captured at the end of EXEC. The captured csr_rvalue is the pre-write value.
- RESP cycle (registered outputs, one-cycle pulses):
  - rf_we=1 for CSR ops with no exception/interrupt and in_rd!=0; rf_wdata = captured old value.
  - flush=1 for an exception or interrupt (flush_pc=ex_entry), for ERTN (flush_pc=era), and for any CSRWR/CSRXCHG (flush_pc=in_pc+4, modulo 2^32).
  - No flush for CSRRD or NOP.
- If has_int rises during RESP or IDLE, it is taken on the next accepted instruction, including a NOP.

Optional Feature:
- Macro: CSR_COMMIT_PERF_EN.
- Defined:
  - perf_ex_cnt increments on each EXEC with wb_ex=1 (includes interrupts).
  - perf_int_cnt increments on each interrupt commit.
  - Both counters are 32-bit, wrap FFFFFFFF->0 and reset to 0.
- Undefined: both ports are tied to 0 and no counter flops are built.

Decomposition:
- Package csr_commit_pkg: in_op encodings, FSM state encoding, ecode constants.
- Optional sub-module csr_commit_perf holds both counters; it is instantiated only under CSR_COMMIT_PERF_EN.

Test Plan:
- CSRRD of num 0x0C, rvalue 0x1C000040, rd=4: csr_re pulses in EXEC with no csr_we; rf_we=1, rf_waddr=4, rf_wdata=0x1C000040 in RESP; no flush.
- CSRXCHG, old 0x000000F0, rj=0x0000000F, rd_val=0xFFFFFFFF, pc=0x1C000100: csr_wmask=0xF, csr_wvalue=0xFFFFFFFF; rf_wdata=0xF0; flush=1, flush_pc=0x1C000104.
- in_ex=1, ecode=0x08, esubcode=1, vaddr=0x1234: wb_ex=1, wb_ecode=0x08, wb_vaddr=0x1234; no csr_we, no rf_we; flush_pc=ex_entry 0x1C008000.
- has_int=1 with a CSRWR offered: interrupt wins; wb_ex=1 with ecode 0; csr_we stays 0; flush_pc=ex_entry.
- ERTN with era=0x1C000200: ertn_flush pulses for 1 cycle; flush_pc=0x1C000200. Reset asserted during EXEC: all strobes 0 immediately; in_ready=1 after release.
- With CSR_COMMIT_PERF_EN, 3 exceptions plus 2 interrupts: perf_ex_cnt=5, perf_int_cnt=2.

Source files
------------

// File: rtl/csr_commit_pkg.sv
// Shared encodings for the CSR commit controller: instruction ops, FSM states, ecodes.
package csr_commit_pkg;

  typedef enum logic [2:0] {
    OP_NOP     = 3'd0,
    OP_CSRRD   = 3'd1,
    OP_CSRWR   = 3'd2,
    OP_CSRXCHG = 3'd3,
    OP_ERTN    = 3'd4
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic [5:0] ECODE_INT_DEF = 6'h00;

  function automatic logic op_is_csr(input logic [2:0] op);
    return (op == OP_CSRRD) || (op == OP_CSRWR) || (op == OP_CSRXCHG);
  endfunction

  function automatic logic op_writes_csr(input logic [2:0] op);
    return (op == OP_CSRWR) || (op == OP_CSRXCHG);
  endfunction

endpackage

// File: rtl/csr_commit_perf.sv
// Exception / interrupt commit counters; 32-bit, free-running with natural wrap.
module csr_commit_perf (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ex_commit_i,
  input  logic        int_commit_i,
  output logic [31:0] ex_cnt_o,
  output logic [31:0] int_cnt_o
);

  logic [31:0] ex_cnt_q, int_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ex_cnt_q  <= '0;
      int_cnt_q <= '0;
    end else begin
      if (ex_commit_i)  ex_cnt_q  <= ex_cnt_q + 32'd1;
      if (int_commit_i) int_cnt_q <= int_cnt_q + 32'd1;
    end
  end

  assign ex_cnt_o  = ex_cnt_q;
  assign int_cnt_o = int_cnt_q;

endmodule

// File: rtl/csr_commit_ctrl.sv
// Writeback-side CSR commit controller: serialises CSR ops, ERTN and exceptions.
// Define CSR_COMMIT_PERF_EN to build the exception/interrupt performance counters.
module csr_commit_ctrl
  import csr_commit_pkg::*;
#(
  parameter int          DATA_W    = 32,
  parameter int          CSRN_W    = 14,
  parameter logic [5:0]  ECODE_INT = ECODE_INT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_pc,
  input  logic [2:0]        in_op,
  input  logic [CSRN_W-1:0] in_csr_num,
  input  logic [DATA_W-1:0] in_rj_val,
  input  logic [DATA_W-1:0] in_rd_val,
  input  logic [4:0]        in_rd,
  input  logic              in_ex,
  input  logic [5:0]        in_ecode,
  input  logic [8:0]        in_esubcode,
  input  logic [DATA_W-1:0] in_vaddr,
  output logic              csr_re,
  output logic [CSRN_W-1:0] csr_num,
  output logic              csr_we,
  output logic [DATA_W-1:0] csr_wmask,
  output logic [DATA_W-1:0] csr_wvalue,
  input  logic [DATA_W-1:0] csr_rvalue,
  input  logic              has_int,
  input  logic [DATA_W-1:0] ex_entry,
  input  logic [DATA_W-1:0] era,
  output logic              wb_ex,
  output logic [DATA_W-1:0] wb_pc,
  output logic [DATA_W-1:0] wb_vaddr,
  output logic [5:0]        wb_ecode,
  output logic [8:0]        wb_esubcode,
  output logic              ertn_flush,
  output logic              rf_we,
  output logic [4:0]        rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              flush,
  output logic [DATA_W-1:0] flush_pc,
  output logic [31:0]       perf_ex_cnt,
  output logic [31:0]       perf_int_cnt
);

  state_e state_q, state_d;

  logic              accept;
  logic [DATA_W-1:0] pc_q, rj_q, rdv_q, vaddr_q;
  logic [2:0]        op_q;
  logic [CSRN_W-1:0] num_q;
  logic [4:0]        rd_q;
  logic              ex_q, int_q;
  logic [5:0]        ecode_q;
  logic [8:0]        esub_q;

  logic              exec, trap, take_ertn, take_csr, csr_wr;

  logic              rf_we_q, flush_q;
  logic [4:0]        rf_waddr_q;
  logic [DATA_W-1:0] rf_wdata_q, flush_pc_q;

  assign accept = in_valid && in_ready;

  // FSM: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (in_valid) state_d = ST_EXEC;
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Instruction capture; the pending interrupt is sampled together with the fields.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q    <= '0;
      op_q    <= '0;
      num_q   <= '0;
      rj_q    <= '0;
      rdv_q   <= '0;
      rd_q    <= '0;
      ex_q    <= 1'b0;
      int_q   <= 1'b0;
      ecode_q <= '0;
      esub_q  <= '0;
      vaddr_q <= '0;
    end else if (accept) begin
      pc_q    <= in_pc;
      op_q    <= in_op;
      num_q   <= in_csr_num;
      rj_q    <= in_rj_val;
      rdv_q   <= in_rd_val;
      rd_q    <= in_rd;
      ex_q    <= in_ex;
      int_q   <= has_int;
      ecode_q <= in_ecode;
      esub_q  <= in_esubcode;
      vaddr_q <= in_vaddr;
    end
  end

  // Classification: interrupt > exception > ERTN > CSR op
  assign exec      = (state_q == ST_EXEC);
  assign trap      = int_q || ex_q;
  assign take_ertn = !trap && (op_q == OP_ERTN);
  assign take_csr  = !trap && op_is_csr(op_q);
  assign csr_wr    = take_csr && op_writes_csr(op_q);

  // FSM: outputs
  always_comb begin
    in_ready    = (state_q == ST_IDLE);
    csr_re      = exec && take_csr;
    csr_we      = exec && csr_wr;
    csr_wmask   = '0;
    csr_wvalue  = '0;
    if (csr_we) begin
      csr_wmask  = (op_q == OP_CSRWR) ? '1 : rj_q;
      csr_wvalue = rdv_q;
    end
    wb_ex       = exec && trap;
    ertn_flush  = exec && take_ertn;
    wb_ecode    = int_q ? ECODE_INT : ecode_q;
    wb_esubcode = int_q ? 9'd0 : esub_q;
    wb_pc       = pc_q;
    wb_vaddr    = vaddr_q;
  end

  assign csr_num = num_q;

  // EXEC -> RESP boundary: old CSR value and redirect target captured here
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rf_we_q    <= 1'b0;
      flush_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      flush_pc_q <= '0;
    end else begin
      rf_we_q <= exec && take_csr && (rd_q != 5'd0);
      flush_q <= exec && (trap || take_ertn || csr_wr);
      if (exec) begin
        rf_waddr_q <= rd_q;
        rf_wdata_q <= csr_rvalue;
        flush_pc_q <= trap ? ex_entry : (take_ertn ? era : pc_q + DATA_W'(4));
      end
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
  assign flush    = flush_q;
  assign flush_pc = flush_pc_q;

`ifdef CSR_COMMIT_PERF_EN
  csr_commit_perf u_perf (
    .clk_i        (clk),
    .rst_i        (reset),
    .ex_commit_i  (wb_ex),
    .int_commit_i (exec && int_q),
    .ex_cnt_o     (perf_ex_cnt),
    .int_cnt_o    (perf_int_cnt)
  );
`else
  assign perf_ex_cnt  = 32'd0;
  assign perf_int_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_csr_commit_ctrl.sv
// Scoreboard bench for csr_commit_ctrl with a small CSR file model on the target side.
module tb_csr_commit_ctrl;
  import csr_commit_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [31:0] in_pc, in_rj_val, in_rd_val, in_vaddr;
  logic [2:0]  in_op;
  logic [13:0] in_csr_num, csr_num;
  logic [4:0]  in_rd, rf_waddr;
  logic        in_ex;
  logic [5:0]  in_ecode, wb_ecode;
  logic [8:0]  in_esubcode, wb_esubcode;
  logic        csr_re, csr_we, wb_ex, ertn_flush, rf_we, flush, has_int;
  logic [31:0] csr_wmask, csr_wvalue, csr_rvalue, ex_entry, era;
  logic [31:0] wb_pc, wb_vaddr, rf_wdata, flush_pc, perf_ex_cnt, perf_int_cnt;

  always #5 clk = ~clk;

  csr_commit_ctrl dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_op(in_op), .in_csr_num(in_csr_num), .in_rj_val(in_rj_val),
    .in_rd_val(in_rd_val), .in_rd(in_rd), .in_ex(in_ex), .in_ecode(in_ecode),
    .in_esubcode(in_esubcode), .in_vaddr(in_vaddr), .csr_re(csr_re), .csr_num(csr_num),
    .csr_we(csr_we), .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue), .csr_rvalue(csr_rvalue),
    .has_int(has_int), .ex_entry(ex_entry), .era(era), .wb_ex(wb_ex), .wb_pc(wb_pc),
    .wb_vaddr(wb_vaddr), .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode),
    .ertn_flush(ertn_flush), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .flush(flush), .flush_pc(flush_pc), .perf_ex_cnt(perf_ex_cnt), .perf_int_cnt(perf_int_cnt)
  );

  // Target-side CSR file (16 entries, aliased on the low nibble of the number)
  logic        env_init;
  logic [31:0] env_csr [16];
  assign csr_rvalue = env_csr[csr_num[3:0]];

  always @(posedge clk) begin
    if (env_init) begin
      for (int i = 0; i < 16; i++) env_csr[i] <= 32'hA500_0000 | 32'(i);
    end else if (csr_we) begin
      env_csr[csr_num[3:0]] <= (env_csr[csr_num[3:0]] & ~csr_wmask) | (csr_wvalue & csr_wmask);
    end
  end

  typedef struct packed {
    logic        re, we;
    logic [31:0] wmask, wvalue;
    logic [13:0] num;
    logic        wbex, chkva;
    logic [5:0]  ecode;
    logic [8:0]  esub;
    logic [31:0] pc, vaddr;
    logic        ertn, rfwe;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        fl;
    logic [31:0] fpc;
  } exp_t;

  exp_t        q[$];
  logic [31:0] ref_csr [16];
  int          n_chk = 0, n_fail = 0;
  int          exp_ex = 0, exp_int = 0;
  logic        mon_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  // Reference model: derive the whole transaction outcome from the instruction rules.
  task automatic issue(input logic irq, input logic ex, input logic [2:0] op,
                       input logic [13:0] num, input logic [31:0] pc, input logic [31:0] rj,
                       input logic [31:0] rdv, input logic [4:0] rd, input logic [5:0] ecode,
                       input logic [8:0] esub, input logic [31:0] vaddr,
                       input logic [31:0] entry, input logic [31:0] eraa);
    exp_t        e;
    logic [31:0] old, mask;
    int          n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    if (!in_ready) chk("ready_timeout", 0, 1);
    e = '0;
    e.num = num;
    old = ref_csr[num[3:0]];
    if (irq) begin
      e.wbex = 1; e.ecode = 6'h00; e.esub = 0; e.pc = pc; e.fl = 1; e.fpc = entry;
      exp_ex++; exp_int++;
    end else if (ex) begin
      e.wbex = 1; e.chkva = 1; e.ecode = ecode; e.esub = esub; e.pc = pc; e.vaddr = vaddr;
      e.fl = 1; e.fpc = entry;
      exp_ex++;
    end else if (op == 3'd4) begin
      e.ertn = 1; e.fl = 1; e.fpc = eraa;
    end else if (op >= 3'd1 && op <= 3'd3) begin
      e.re = 1;
      e.rfwe = (rd != 0); e.waddr = rd; e.wdata = old;
      if (op != 3'd1) begin
        mask = (op == 3'd2) ? 32'hFFFF_FFFF : rj;
        e.we = 1; e.wmask = mask; e.wvalue = rdv;
        e.fl = 1; e.fpc = pc + 32'd4;
        ref_csr[num[3:0]] = (old & ~mask) | (rdv & mask);
      end
    end
    q.push_back(e);
    has_int = irq; in_ex = ex; in_op = op; in_csr_num = num; in_pc = pc; in_rj_val = rj;
    in_rd_val = rdv; in_rd = rd; in_ecode = ecode; in_esubcode = esub; in_vaddr = vaddr;
    ex_entry = entry; era = eraa; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Monitor: a busy window is EXEC then RESP; outputs compared against the queued model
  initial begin
    int   phase;
    exp_t c;
    phase = 0;
    c = '0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (!in_ready) begin
          if (phase == 0) begin
            if (q.size() == 0) begin
              chk("unexpected_exec", 0, 1);
              c = '0;
            end else c = q.pop_front();
            chk("csr_re", csr_re, c.re);
            chk("csr_we", csr_we, c.we);
            chk("csr_num", csr_num, c.num);
            if (c.we) begin
              chk("csr_wmask", csr_wmask, c.wmask);
              chk("csr_wvalue", csr_wvalue, c.wvalue);
            end
            chk("wb_ex", wb_ex, c.wbex);
            if (c.wbex) begin
              chk("wb_ecode", wb_ecode, c.ecode);
              chk("wb_esubcode", wb_esubcode, c.esub);
              chk("wb_pc", wb_pc, c.pc);
              if (c.chkva) chk("wb_vaddr", wb_vaddr, c.vaddr);
            end
            chk("ertn_flush", ertn_flush, c.ertn);
            chk("exec_resp_quiet", {rf_we, flush}, 0);
            phase = 1;
          end else if (phase == 1) begin
            chk("resp_exec_quiet", {csr_re, csr_we, wb_ex, ertn_flush}, 0);
            chk("rf_we", rf_we, c.rfwe);
            if (c.rfwe) begin
              chk("rf_waddr", rf_waddr, c.waddr);
              chk("rf_wdata", rf_wdata, c.wdata);
            end
            chk("flush", flush, c.fl);
            if (c.fl) chk("flush_pc", flush_pc, c.fpc);
            phase = 2;
          end else begin
            chk("busy_too_long", phase, 1);
          end
        end else begin
          if (phase == 1) chk("resp_missing", phase, 2);
          phase = 0;
          chk("idle_quiet", {csr_re, csr_we, wb_ex, ertn_flush, rf_we, flush}, 0);
        end
      end
    end
  end

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || !in_ready) && n < 100) begin @(negedge clk); n++; end
    repeat (2) @(negedge clk);
    chk("drain_queue_empty", q.size(), 0);
  endtask

  initial begin
    in_valid = 0; in_pc = 0; in_op = 0; in_csr_num = 0; in_rj_val = 0; in_rd_val = 0;
    in_rd = 0; in_ex = 0; in_ecode = 0; in_esubcode = 0; in_vaddr = 0; has_int = 0;
    ex_entry = 0; era = 0;
    for (int i = 0; i < 16; i++) ref_csr[i] = 32'hA500_0000 | 32'(i);
    reset = 1'b1; env_init = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_strobes", {csr_re, csr_we, wb_ex, ertn_flush, rf_we, flush}, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_csr_num", csr_num, 0);
    chk("rst_data", {rf_wdata, flush_pc}, 0);
    chk("rst_perf", {perf_ex_cnt, perf_int_cnt}, 0);
    @(negedge clk);
    reset = 1'b0; env_init = 1'b0; mon_en = 1'b1;

    // Directed cases from the test plan, plus PC wrap and interrupt on a NOP
    issue(0, 0, 3'd2, 14'h00C, 32'h1C00_0000, 0, 32'h1C00_0040, 5'd0, 0, 0, 0, 0, 0);
    issue(0, 0, 3'd1, 14'h00C, 32'h1C00_0004, 0, 0, 5'd4, 0, 0, 0, 0, 0);
    issue(0, 0, 3'd2, 14'h005, 32'h1C00_0008, 0, 32'h0000_00F0, 5'd0, 0, 0, 0, 0, 0);
    issue(0, 0, 3'd3, 14'h005, 32'h1C00_0100, 32'h0000_000F, 32'hFFFF_FFFF, 5'd7, 0, 0, 0, 0, 0);
    issue(0, 1, 3'd2, 14'h005, 32'h1C00_0110, 0, 32'h1, 5'd3, 6'h08, 9'd1, 32'h1234, 32'h1C00_8000, 0);
    issue(1, 0, 3'd2, 14'h005, 32'h1C00_0120, 0, 32'h2, 5'd3, 0, 0, 0, 32'h1C00_8000, 0);
    issue(0, 0, 3'd4, 14'h000, 32'h1C00_0130, 0, 0, 5'd0, 0, 0, 0, 32'h1C00_8000, 32'h1C00_0200);
    issue(1, 0, 3'd0, 14'h000, 32'h1C00_0140, 0, 0, 5'd0, 0, 0, 0, 32'h1C00_9000, 0);
    issue(0, 0, 3'd2, 14'h009, 32'hFFFF_FFFC, 0, 32'h55, 5'd9, 0, 0, 0, 0, 0);
    drain();

    // Asynchronous reset during EXEC of a CSRWR: no write may land
    mon_en = 1'b0;
    @(negedge clk);
    has_int = 0; in_ex = 0; in_op = 3'd2; in_csr_num = 14'h006; in_rd_val = 32'hDEAD_BEEF;
    in_rd = 5'd2; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    chk("exec_we_before_rst", csr_we, 1);
    reset = 1'b1;
    #1;
    chk("async_rst_strobes", {csr_re, csr_we, wb_ex, ertn_flush, rf_we, flush}, 0);
    chk("async_rst_csr_num", csr_num, 0);
    @(negedge clk);
    reset = 1'b0;
    exp_ex = 0; exp_int = 0;
    @(negedge clk);
    chk("rst_release_ready", in_ready, 1);
    chk("aborted_write", env_csr[6], ref_csr[6]);
    mon_en = 1'b1;

    // Three exceptions and two interrupts
    for (int i = 0; i < 3; i++)
      issue(0, 1, 3'd1, 14'h001, 32'h1C00_1000 + 32'(i * 4), 0, 0, 5'd1, 6'h0A, 9'(i), 32'(i), 32'h1C00_8000, 0);
    for (int i = 0; i < 2; i++)
      issue(1, 0, 3'd3, 14'h002, 32'h1C00_2000 + 32'(i * 4), 32'hFF, 32'h1, 5'd1, 0, 0, 0, 32'h1C00_8800, 0);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      logic irq, ex;
      irq = ($urandom_range(0, 7) == 0);
      ex  = ($urandom_range(0, 7) == 0);
      issue(irq, ex, 3'($urandom_range(0, 4)), 14'($urandom), $urandom, $urandom, $urandom,
            5'($urandom_range(0, 31)), 6'($urandom), 9'($urandom), $urandom, $urandom, $urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();

`ifdef CSR_COMMIT_PERF_EN
    chk("perf_ex_cnt", perf_ex_cnt, 32'(exp_ex));
    chk("perf_int_cnt", perf_int_cnt, 32'(exp_int));
`else
    chk("perf_ex_cnt_off", perf_ex_cnt, 0);
    chk("perf_int_cnt_off", perf_int_cnt, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
